product_bcd: RTL and testbench

PRODUCT_BCD -- requirements
Module: product_bcd

---
 rtl/product_bcd_pkg.sv | 18 +
 rtl/product_bcd_add3.sv | 12 +
 rtl/product_bcd.sv | 97 +++++++++
 tb/tb_product_bcd.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD product converter.
// Supplies the FSM encoding, product width, digit geometry and add-3 threshold.
package product_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int IN_W       = 8;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;

  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADD3_INC    = 4'd3;

endpackage

// File: rtl/product_bcd_add3.sv
// Double-dabble nibble correction: adds 3 when the digit is 5 or more.
// Ports: nibIn (BCD nibble before shift), nibOut (corrected nibble).
module bcd_add3
  import product_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibIn,
  output logic [DIGIT_W-1:0] nibOut
);

  assign nibOut = (nibIn >= ADD3_THRESH) ? nibIn + ADD3_INC : nibIn;

endmodule

// File: rtl/product_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter, one bit per clock.
// Ports: clk, rst (async high), product/in_valid/in_ready in,
// bcd_hundreds/bcd_tens/bcd_ones/out_valid/out_ready out.
module product_bcd
  import product_bcd_pkg::*;
#(
  parameter int IN_W = product_bcd_pkg::IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] product,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [3:0]      bcd_hundreds,
  output logic [3:0]      bcd_tens,
  output logic [3:0]      bcd_ones,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int BCD_W  = DIGIT_W * NUM_DIGITS;
  localparam int WORK_W = BCD_W + IN_W;
  localparam int CNT_W  = $clog2(IN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

  state_t state, nextState;

  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  shifted;
  logic [BCD_W-1:0]   adjBcd;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT_W-1:0] hundreds, tens, ones;
  logic               outValid;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nibIn  (work[IN_W + i*DIGIT_W +: DIGIT_W]),
      .nibOut (adjBcd[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Correct every nibble, then shift; the dropped MSB is always zero.
  assign shifted = {adjBcd[BCD_W-2:0], work[IN_W-1:0], 1'b0};

  assign in_ready     = (state == IDLE);
  assign out_valid    = outValid;
  assign bcd_hundreds = hundreds;
  assign bcd_tens     = tens;
  assign bcd_ones     = ones;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (in_valid)       nextState = SHIFT;
      SHIFT:   if (cnt == LAST)    nextState = DONE;
      DONE:    if (out_ready)      nextState = IDLE;
      default:                     nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
      outValid <= 1'b0;
    end else begin
      state <= nextState;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work <= {{BCD_W{1'b0}}, product};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            hundreds <= shifted[IN_W + 2*DIGIT_W +: DIGIT_W];
            tens     <= shifted[IN_W + DIGIT_W +: DIGIT_W];
            ones     <= shifted[IN_W +: DIGIT_W];
            outValid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd.sv
// Directed bench for product_bcd with a digit scoreboard.
// Covers reset, latency, backpressure, abort, ignore-while-busy, full sweep.
module tb_product_bcd;

  logic       clk;
  logic       rst;
  logic [7:0] product;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       out_valid;
  logic       out_ready;

  logic [11:0] dig;
  logic [11:0] sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int prevAcc = -1;

  assign dig = {bcd_hundreds, bcd_tens, bcd_ones};

  product_bcd #(.IN_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .product      (product),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge with the DUT idle. mode: 0 in_valid low while
  // busy, 1 held high, 2 random toggling. Product is scrambled while busy.
  task automatic runOne(input int v, input int hold, input int mode,
                        input bit gap);
    logic [11:0] e;
    logic [11:0] want;
    int n;
    int acc;
    product  = 8'(v);
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    e = ref_bcd(v);
    sb.push_back(e);
    if (hold > 0) out_ready = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    if (gap && prevAcc >= 0) chk("accept_gap", acc - prevAcc, 10);
    prevAcc = acc;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      product = 8'($urandom);
      if (mode == 0) in_valid = 1'b0;
      else if (mode == 1) in_valid = 1'b1;
      else in_valid = 1'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, 8);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      want = e;
    end else begin
      want = sb.pop_front();
    end
    chk("digits", 32'(dig), 32'(want));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_digits", 32'(dig), 32'(e));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    if (mode != 1) in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_digits", 32'(dig), 32'(e));
  endtask

  initial begin
    rst       = 1'b1;
    product   = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_digits", 32'(dig), 32'd0);

    rst = 1'b0;
    runOne(0, 0, 0, 1'b0);
    runOne(255, 0, 0, 1'b0);
    runOne(225, 0, 0, 1'b0);
    runOne(99, 0, 0, 1'b0);
    runOne(100, 5, 0, 1'b0);

    product  = 8'd200;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    product  = 8'd77;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_digits", 32'(dig), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    runOne(42, 0, 0, 1'b0);

    runOne(137, 0, 2, 1'b0);

    prevAcc = -1;
    for (int v = 0; v < 256; v++) runOne(v, 0, 1, 1'b1);
    in_valid = 1'b0;

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
